// File: rtl/mulmod_arbiter.sv
// Round-robin arbiter in front of a shared 1-cycle registered modular multiplier.
// Requester tags ride alongside the operation and results drain through a credit-protected FIFO.
`ifndef D_width
`define D_width 16
`endif

module mulmod_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = `D_width,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    output logic                          mul_valid,
    input  logic [DATA_WIDTH-1:0]         mul_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic                          busy
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 2;
    localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH;

    // Handshake: a transfer happens on a cycle where valid and ready are both 1.
    // A producer holds valid and its payload until that cycle; ready may depend on valid.

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                  mul_valid_q, mul_valid_d;
    logic [ID_WIDTH-1:0]   id1_q, id1_d, id2_q, id2_d;
    logic                  v2_q, v2_d;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;

    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   cand_idx;
    logic [CNT_W-1:0]      cnt;
    logic                  can_issue;
    logic                  hs;
    logic                  push;
    logic                  pop;

    // Search starts just past the last winner, so every waiting requester is served within NUM_REQ grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = rr_ptr_q;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Every op occupies one credit from issue until its result leaves the FIFO.
    assign pop       = rsp_valid_q & rsp_ready;
    assign push      = v2_q;
    assign cnt       = CNT_W'(mul_valid_q) + CNT_W'(v2_q) + fifo_cnt_q;
    assign can_issue = (cnt < CNT_W'(FIFO_DEPTH)) | pop;
    assign hs        = grant_found & can_issue;

    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_valid_d = hs;
        id1_d       = id1_q;
        v2_d        = mul_valid_q;
        id2_d       = id1_q;
        if (hs) begin
            rr_ptr_d = grant_idx;
            mul_a_d  = req_a[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            mul_b_d  = req_b[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            id1_d    = grant_idx;
        end
    end

    // The head is re-registered from next-state FIFO contents so rsp_* are flops and hold after the last pop.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {id2_q, mul_result};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        rsp_valid_d = (fifo_cnt_d != '0);
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (rsp_valid_d) begin
            {rsp_id_d, rsp_data_d} = mem_d[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_valid_q <= 1'b0;
            id1_q       <= '0;
            v2_q        <= 1'b0;
            id2_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_valid_q <= mul_valid_d;
            id1_q       <= id1_d;
            v2_q        <= v2_d;
            id2_q       <= id2_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    // A push into a full FIFO without a simultaneous pop means the credit accounting is broken.
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_valid = mul_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = mul_valid_q | v2_q | rsp_valid_q;

endmodule

// File: tb/tb_mulmod_arbiter.sv
// Bench for mulmod_arbiter: a mod-97 multiplier model, single-op vector table,
// and hand-written sequences for fairness, backpressure, full-FIFO pulse and mid-operation reset.
module tb_mulmod_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int IW = 2;
    localparam int Q  = 97;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            mul_valid;
    logic [DW-1:0]   mul_result;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IW+DW-1:0] exp_q[$];

    typedef struct {
        int        id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    mulmod_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_valid (mul_valid),
        .mul_result(mul_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    // ---------------- clock / reset / multiplier model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mul_result <= DW'((32'(mul_a) * 32'(mul_b)) % Q);
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_mul_b", 32'(mul_b), 0);
        check("rst_mul_valid", 32'(mul_valid), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_slot(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (busy && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("drain_idle", 32'(busy), 0);
        check("drain_queue_empty", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        set_slot(v.id, v.a, v.b);
        req_valid = NR'(1) << v.id;
        @(negedge clk);
        check("vec_ready_cycle0", 32'(req_ready), 32'(1) << v.id);
        @(posedge clk);
        #1;
        req_valid = '0;
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 1) check("vec_busy_c1", 32'(busy), 1);
            if (rsp_valid) lat = c;
        end
        check("vec_latency", 32'(lat), 3);
        check("vec_rsp_data", 32'(rsp_data), 32'(v.exp_data));
        check("vec_rsp_id", 32'(rsp_id), 32'(v.id));
        @(negedge clk);
        check("vec_busy_c4", 32'(busy), 0);
        check("vec_rsp_valid_c4", 32'(rsp_valid), 0);
        check("vec_data_hold", 32'(rsp_data), 32'(v.exp_data));
    endtask

    // ---------------- scoreboard / monitor ----------------
    int            mon_g;
    logic [DW-1:0] mon_a;
    logic [DW-1:0] mon_b;
    logic [IW+DW-1:0] mon_e;

    always @(negedge clk) begin
        if (!rst) begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 1);
            check("ready_only_valid", 32'(req_ready & ~req_valid), 0);
            if (|(req_valid & req_ready)) begin
                mon_g = 0;
                for (int i = 0; i < NR; i++) begin
                    if (req_ready[i]) mon_g = i;
                end
                mon_a = req_a[mon_g*DW +: DW];
                mon_b = req_b[mon_g*DW +: DW];
                exp_q.push_back({IW'(mon_g), DW'((32'(mon_a) * 32'(mon_b)) % Q)});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got id %0d data %0d with no expected entry", rsp_id, rsp_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_rsp_data", 32'(rsp_data), 32'(mon_e[DW-1:0]));
                    check("sb_rsp_id", 32'(rsp_id), 32'(mon_e[IW+DW-1:DW]));
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int acc;
        int seq[3];

        vecs[0] = '{id: 1, a: 16'd10, b: 16'd20, exp_data: 16'd6};
        vecs[1] = '{id: 2, a: 16'd0,  b: 16'd55, exp_data: 16'd0};
        vecs[2] = '{id: 3, a: 16'd96, b: 16'd96, exp_data: 16'd1};
        vecs[3] = '{id: 0, a: 16'd50, b: 16'd2,  exp_data: 16'd3};
        vecs[4] = '{id: 2, a: 16'd96, b: 16'd2,  exp_data: 16'd95};
        vecs[5] = '{id: 1, a: 16'd12, b: 16'd34, exp_data: 16'd20};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        do_reset();

        // single ops from the vector table
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end
        wait_idle();

        // all requesters valid: strict rotation, one op per cycle
        do_reset();
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) set_slot(i, DW'(i + 1), DW'(i + 10));
        req_valid = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rr_grant", 32'(req_ready), 32'(1) << (k % NR));
            if (k >= 3) check("rr_no_bubble", 32'(rsp_valid), 1);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_idle();

        // backpressure: exactly FIFO_DEPTH accepts with rsp_ready low
        rsp_ready = 1'b0;
        set_slot(0, 16'd96, 16'd96);
        req_valid = 4'b0001;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready[0]) acc++;
            if (k >= 4) check("bp_ready_zero", 32'(req_ready), 0);
            if (k >= 3) check("bp_rsp_hold", 32'(rsp_data), 1);
            @(posedge clk);
            #1;
        end
        check("bp_accepts", 32'(acc), 4);
        @(negedge clk);
        check("bp_rsp_valid", 32'(rsp_valid), 1);
        check("bp_rsp_id", 32'(rsp_id), 0);
        @(posedge clk);
        #1;

        // full FIFO, one-cycle pop pulse: exactly one grant in the same cycle
        rsp_ready = 1'b1;
        @(negedge clk);
        check("pulse_grant", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("pulse_credits_full", 32'(req_ready), 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("stream_ready", 32'(req_ready), 1);
            check("stream_rsp_valid", 32'(rsp_valid), 1);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_idle();

        // reset with two ops in the pipe and two buffered
        rsp_ready = 1'b0;
        set_slot(0, 16'd7, 16'd8);
        req_valid = 4'b0001;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 1);
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("post_reset_no_rsp", 32'(rsp_valid), 0);
            check("post_reset_idle", 32'(busy), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) set_slot(i, DW'(i + 2), DW'(3));
        req_valid = 4'hF;
        @(negedge clk);
        check("post_reset_first_grant", 32'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = '0;
        wait_idle();

        // mixed operands on req2/req3 alternating with req0; pointer now at 0
        seq[0] = 2;
        seq[1] = 3;
        seq[2] = 0;
        set_slot(0, 16'd5, 16'd7);
        set_slot(2, 16'd0, 16'd37);
        set_slot(3, 16'd96, 16'd96);
        req_valid = 4'b1101;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("mix_fair_grant", 32'(req_ready), 32'(1) << seq[k % 3]);
            if (k >= 3 && rsp_id == 2'd2) check("mix_zero_product", 32'(rsp_data), 0);
            if (k >= 3 && rsp_id == 2'd3) check("mix_qm1_product", 32'(rsp_data), 1);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        wait_idle();

        check("final_queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
